fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives a single-outstanding request/grant/rvalid instruction-memory port.
- Presents {pc_out, inst_out, inst_valid} to IF/ID. IF/ID bubble is driven as ~inst_valid | redirect.
- Honours pipeline pause and branch/jump redirect, and buffers one in-flight response so a late pause never loses an instruction.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_skid.sv | 90 +++++++++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: the canonical NOP
// and the fetch state encoding.
package fetch_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // IDLE: nothing in flight; WAIT: one request granted, response pending;
    // KILL: one request in flight whose response must be discarded.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_KILL = 2'd2
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/rvalid port (single outstanding request).
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_skid.sv
// Two-entry instruction buffer: the "out" entry drives the IF/ID outputs,
// the skid entry catches a response that lands while out is held.
module fetch_skid
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [31:0]     push_inst_i,
    input  logic            pop_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [31:0]     out_inst_o,
    output logic            space_o
);
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_inst_q, out_inst_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_inst_q, skid_inst_d;

    // Next buffer contents: flush beats pop beats push. A push never meets a
    // full skid because the fetch side only issues when skid will be empty.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop_i && out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_inst_d   = skid_inst_q;
                skid_valid_d = 1'b0;
            end else if (push_i) begin
                out_valid_d = 1'b1;
                out_pc_d    = push_pc_i;
                out_inst_d  = push_inst_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push_i) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_pc_d    = push_pc_i;
                out_inst_d  = push_inst_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = push_pc_i;
                skid_inst_d  = push_inst_i;
            end
        end
    end

    // Buffer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_inst_q   <= INST_NOP;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= INST_NOP;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_pc_o    = out_pc_q;
    assign out_inst_o  = out_inst_q;
    // Skid empty after this edge: any response to a request issued now has a slot.
    assign space_o     = ~skid_valid_d;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the single-outstanding
// instruction-memory port, handles pause/redirect and drops killed responses.
// Optional feature: define FETCH_MISALIGN_EN to trap misaligned redirect targets.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            pause,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     inst_out,
    output logic            inst_valid,
    output logic            fetch_fault
);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req, grant, push, space;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            fault_q;

    // Only a response to a live (non-killed) request is kept, and never
    // one that arrives together with a redirect.
    assign push = imem.rvalid & (state_q == FS_WAIT) & ~redirect;

    fetch_skid #(.XLEN(XLEN)) u_skid (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush_i     (redirect),
        .push_i      (push),
        .push_pc_i   (req_pc_q),
        .push_inst_i (imem.rdata),
        .pop_i       (~pause),
        .out_valid_o (out_valid),
        .out_pc_o    (out_pc),
        .out_inst_o  (out_inst),
        .space_o     (space)
    );

    // Issue decision, fetch state and PC next-state; redirect has priority.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req        = reset_n & ~redirect & ~fault_q & (state_q != FS_KILL)
                   & ((state_q == FS_IDLE) | imem.rvalid) & space;
        grant      = req & imem.gnt;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            state_d    = ((state_q != FS_IDLE) && !imem.rvalid) ? FS_KILL : FS_IDLE;
        end else if (grant) begin
            state_d    = FS_WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else if (imem.rvalid) begin
            state_d = FS_IDLE;
        end
    end

    // Fetch state and PC registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign imem.req  = req;
    assign imem.addr = fetch_pc_q;

`ifdef FETCH_MISALIGN_EN
    logic [XLEN-1:0] fault_pc_q;

    // A misaligned redirect target parks a faulting NOP until the next redirect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (redirect) begin
            fault_q    <= is_misaligned(redirect_pc[1:0]);
            fault_pc_q <= redirect_pc;
        end
    end

    assign inst_valid  = fault_q | out_valid;
    assign pc_out      = fault_q ? fault_pc_q : out_pc;
    assign inst_out    = fault_q ? INST_NOP : out_inst;
    assign fetch_fault = fault_q;
`else
    assign fault_q     = 1'b0;
    assign inst_valid  = out_valid;
    assign pc_out      = out_pc;
    assign inst_out    = out_inst;
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pause = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        fetch_fault;

    int checks = 0;
    int passed = 0;

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .pause       (pause),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .inst_valid  (inst_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // Memory model: response exactly mem_lat cycles after the grant edge.
    int          mem_lat = 1;
    logic        s_fire = 1'b0;
    logic [31:0] s_addr = '0;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    int          cnt = 0;

    initial begin
        imem.gnt    = 1'b1;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
    end

    always @(negedge clk) begin
        s_fire = imem.req & imem.gnt;
        s_addr = imem.addr;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend = 1'b0;
            cnt = 0;
            imem.rvalid = 1'b0;
        end else begin
            imem.rvalid = 1'b0;
            if (s_fire) begin
                pend = 1'b1;
                paddr = s_addr;
                cnt = mem_lat;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem.rvalid = 1'b1;
                    imem.rdata = inst_of(paddr);
                    pend = 1'b0;
                end
            end
        end
    end

    // One line per instruction handed to IF/ID.
    always @(negedge clk) begin
        if (rst_n && inst_valid && !pause && !redirect)
            $display("consume pc=%h inst=%h fault=%0b", pc_out, inst_out, fetch_fault);
    end

    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int lat, input logic g);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pause = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem.gnt = g;
        mem_lat = lat;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (imem.req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem.req); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", inst_valid); else passed++;
        checks++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc_out); else passed++;
        checks++; if (inst_out !== INST_NOP) $display("FAIL rst_inst got %h exp %h", inst_out, INST_NOP); else passed++;
        checks++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", fetch_fault); else passed++;
        checks++; if (imem.addr !== 32'h100) $display("FAIL rst_addr got %h exp 100", imem.addr); else passed++;
    endtask

    task automatic test_stream;
        do_reset(1, 1'b1);
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) $display("FAIL stream_c0 got req=%b addr=%h exp 1/100", imem.req, imem.addr); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL stream_c0_valid got %b exp 0", inst_valid); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h104) $display("FAIL stream_c1 got req=%b addr=%h exp 1/104", imem.req, imem.addr); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL stream_c1_valid got %b exp 0", inst_valid); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (imem.addr !== 32'h108) $display("FAIL stream_c2_addr got %h exp 108", imem.addr); else passed++;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h100 || inst_out !== inst_of(32'h100))
            $display("FAIL stream_c2_out got v=%b pc=%h inst=%h exp 1/100/%h", inst_valid, pc_out, inst_out, inst_of(32'h100)); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (pc_out !== 32'h104 || imem.addr !== 32'h10C) $display("FAIL stream_c3 got pc=%h addr=%h exp 104/10c", pc_out, imem.addr); else passed++;
    endtask

    task automatic test_pause;
        do_reset(1, 1'b1);
        repeat (3) next_cycle();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h104 || inst_out !== inst_of(32'h104))
                $display("FAIL pause_hold%0d got v=%b pc=%h inst=%h exp 1/104", i, inst_valid, pc_out, inst_out); else passed++;
            checks++; if (imem.req !== 1'b0) $display("FAIL pause_noreq%0d got %b exp 0", i, imem.req); else passed++;
            next_cycle();
        end
        pause = 1'b0;
        @(negedge clk);
        checks++; if (pc_out !== 32'h104 || imem.req !== 1'b1 || imem.addr !== 32'h10C)
            $display("FAIL pause_release got pc=%h req=%b addr=%h exp 104/1/10c", pc_out, imem.req, imem.addr); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h108 || inst_out !== inst_of(32'h108))
            $display("FAIL pause_skid_out got v=%b pc=%h inst=%h exp 1/108", inst_valid, pc_out, inst_out); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h10C || inst_out !== inst_of(32'h10C))
            $display("FAIL pause_next got v=%b pc=%h inst=%h exp 1/10c", inst_valid, pc_out, inst_out); else passed++;
    endtask

    task automatic test_redirect_kill;
        do_reset(2, 1'b1);
        repeat (7) next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        checks++; if (pc_out !== 32'h108 || imem.req !== 1'b0) $display("FAIL kill_c7 got pc=%h req=%b exp 108/0", pc_out, imem.req); else passed++;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0 || imem.req !== 1'b0) $display("FAIL kill_drop got v=%b req=%b exp 0/0", inst_valid, imem.req); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h200 || inst_valid !== 1'b0)
            $display("FAIL kill_newreq got req=%b addr=%h v=%b exp 1/200/0", imem.req, imem.addr, inst_valid); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) $display("FAIL kill_c10 got %b exp 0", inst_valid); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0 || imem.addr !== 32'h204) $display("FAIL kill_c11 got v=%b addr=%h exp 0/204", inst_valid, imem.addr); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h200 || inst_out !== inst_of(32'h200))
            $display("FAIL kill_out got v=%b pc=%h inst=%h exp 1/200", inst_valid, pc_out, inst_out); else passed++;
    endtask

    task automatic test_redirect_rvalid;
        do_reset(1, 1'b1);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        checks++; if (imem.req !== 1'b0) $display("FAIL rvr_noreq got %b exp 0", imem.req); else passed++;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h200 || inst_valid !== 1'b0)
            $display("FAIL rvr_req got req=%b addr=%h v=%b exp 1/200/0", imem.req, imem.addr, inst_valid); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0 || imem.addr !== 32'h204) $display("FAIL rvr_c3 got v=%b addr=%h exp 0/204", inst_valid, imem.addr); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h200) $display("FAIL rvr_out got v=%b pc=%h exp 1/200", inst_valid, pc_out); else passed++;
    endtask

    task automatic test_gnt_stall;
        do_reset(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h100)
                $display("FAIL stall%0d got req=%b addr=%h exp 1/100", i, imem.req, imem.addr); else passed++;
            next_cycle();
        end
        imem.gnt = 1'b1;
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) $display("FAIL stall_gnt got req=%b addr=%h exp 1/100", imem.req, imem.addr); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (imem.addr !== 32'h104 || inst_valid !== 1'b0) $display("FAIL stall_adv got addr=%h v=%b exp 104/0", imem.addr, inst_valid); else passed++;
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h100) $display("FAIL stall_out got v=%b pc=%h exp 1/100", inst_valid, pc_out); else passed++;
    endtask

    task automatic test_misalign;
        do_reset(1, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h202;
        @(negedge clk);
        checks++; if (imem.req !== 1'b0) $display("FAIL mis_noreq got %b exp 0", imem.req); else passed++;
        next_cycle();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || fetch_fault !== 1'b1 || pc_out !== 32'h202 || inst_out !== INST_NOP)
            $display("FAIL mis_fault got v=%b f=%b pc=%h inst=%h exp 1/1/202/%h", inst_valid, fetch_fault, pc_out, inst_out, INST_NOP); else passed++;
        checks++; if (imem.req !== 1'b0) $display("FAIL mis_req got %b exp 0", imem.req); else passed++;
        pause = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (fetch_fault !== 1'b1 || pc_out !== 32'h202) $display("FAIL mis_pause got f=%b pc=%h exp 1/202", fetch_fault, pc_out); else passed++;
        next_cycle();
        pause = 1'b0;
        @(negedge clk);
        checks++; if (fetch_fault !== 1'b1 || imem.req !== 1'b0) $display("FAIL mis_held got f=%b req=%b exp 1/0", fetch_fault, imem.req); else passed++;
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (fetch_fault !== 1'b0 || inst_valid !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h300)
            $display("FAIL mis_clear got f=%b v=%b req=%b addr=%h exp 0/0/1/300", fetch_fault, inst_valid, imem.req, imem.addr); else passed++;
`else
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h202 || fetch_fault !== 1'b0)
            $display("FAIL mis_plain got req=%b addr=%h f=%b exp 1/202/0", imem.req, imem.addr, fetch_fault); else passed++;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h202 || inst_out !== inst_of(32'h202) || fetch_fault !== 1'b0)
            $display("FAIL mis_plain_out got v=%b pc=%h inst=%h f=%b exp 1/202/%h/0", inst_valid, pc_out, inst_out, fetch_fault, inst_of(32'h202)); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_pause();
        test_redirect_kill();
        test_redirect_rvalid();
        test_gnt_stall();
        test_misalign();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
